// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage of the bittyCore pipeline.
// Passes ALU results to write-back. Runs loads and stores on a req/gnt/rvalid
// data bus, then formats load data with byte-lane selection and extension.
// Sets stall_req while a bus transaction is outstanding.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_*                EX/MEM fields (wd, wreg, wdata, mem_re/we, memop, addr, sdata)
//   stall_req           combinational hold for the upstream stages
//   dbus_*              data bus: req/we/addr/be/wdata out, gnt/rvalid/rdata in
//   wb_*                MEM/WB fields (wd, wreg, wdata)
//   misalign_exc        exists only when MISALIGN_EXC_EN is defined
//
// Optional feature, macro MISALIGN_EXC_EN:
//   Misaligned H and W accesses skip the bus. They produce one registered
//   bubble and a one-cycle misalign_exc pulse. Without the macro, the low
//   address bits beyond the lane rules are ignored.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_mem_re,
  input  logic              in_mem_we,
  input  logic [2:0]        in_memop,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [DATA_W-1:0] in_mem_sdata,
  output logic              stall_req,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata
`ifdef MISALIGN_EXC_EN
  ,
  output logic              misalign_exc
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        wb_wd_q, wb_wd_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

  // memop[1:0]: 00 byte, 01 half, other codes word. memop[2] selects zero-extension.
  logic is_b, is_h, is_w, acc, misal, mem_op;
  assign is_b = (in_memop[1:0] == 2'b00);
  assign is_h = (in_memop[1:0] == 2'b01);
  assign is_w = ~is_b & ~is_h;
  assign acc  = in_mem_re | in_mem_we;

`ifdef MISALIGN_EXC_EN
  logic exc_q, exc_d;
  assign misal = acc & ((is_h & in_mem_addr[0]) | (is_w & (in_mem_addr[1:0] != 2'b00)));
  assign exc_d = (state_q == IDLE) & misal;
  assign misalign_exc = exc_q;
`else
  assign misal = 1'b0;
`endif
  assign mem_op = acc & ~misal;

  // Store lane placement
  logic [3:0]        be_new;
  logic [DATA_W-1:0] sdata_new;
  always_comb begin
    be_new    = 4'b1111;
    sdata_new = in_mem_sdata;
    if (is_b) begin
      be_new    = 4'b0001 << in_mem_addr[1:0];
      sdata_new = {4{in_mem_sdata[7:0]}};
    end else if (is_h) begin
      be_new    = 4'b0011 << {in_mem_addr[1], 1'b0};
      sdata_new = {2{in_mem_sdata[15:0]}};
    end
  end

  // Load lane extraction and extension
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (op_q[1:0])
      2'b00:   ld_data = op_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = op_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dbus_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    lane_d     = lane_q;
    op_d       = op_q;
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d   = REQ;
          we_d      = in_mem_we;  // store wins when re and we are both set
          addr_d    = {in_mem_addr[ADDR_W-1:2], 2'b00};
          be_d      = be_new;
          wdata_d   = sdata_new;
          lane_d    = in_mem_addr[1:0];
          op_d      = in_memop;
          wb_wreg_d = 1'b0;
        end else begin
          wb_wd_d    = in_wd;
          wb_wreg_d  = in_wreg & ~misal;
          wb_wdata_d = in_wdata;
        end
      end
      REQ: begin
        wb_wreg_d = 1'b0;
        if (dbus_gnt) begin
          if (we_q) begin
            state_d    = IDLE;
            wb_wd_d    = in_wd;
            wb_wreg_d  = in_wreg;
            wb_wdata_d = in_wdata;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        wb_wreg_d = 1'b0;
        if (dbus_rvalid) begin
          state_d    = IDLE;
          wb_wd_d    = in_wd;
          wb_wreg_d  = in_wreg;
          wb_wdata_d = ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  // Low in the completion cycle, so upstream advances on the same edge
  assign stall_req = ((state_q == IDLE) & mem_op)
                   | ((state_q == REQ)  & ~(we_q & dbus_gnt))
                   | ((state_q == WAIT) & ~dbus_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      lane_q     <= '0;
      op_q       <= '0;
      wb_wd_q    <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= '0;
`ifdef MISALIGN_EXC_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      lane_q     <= lane_d;
      op_q       <= op_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
`ifdef MISALIGN_EXC_EN
      exc_q      <= exc_d;
`endif
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign wb_wd      = wb_wd_q;
  assign wb_wreg    = wb_wreg_q;
  assign wb_wdata   = wb_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic [31:0] in_wdata;
  logic        in_mem_re, in_mem_we;
  logic [2:0]  in_memop;
  logic [31:0] in_mem_addr, in_mem_sdata;
  logic        stall_req, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
`ifdef MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
`ifdef MISALIGN_EXC_EN
    .misalign_exc(misalign_exc),
`endif
    .clk(clk), .rst(rst),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_mem_re(in_mem_re), .in_mem_we(in_mem_we), .in_memop(in_memop),
    .in_mem_addr(in_mem_addr), .in_mem_sdata(in_mem_sdata),
    .stall_req(stall_req),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_t;
  typedef struct { logic [4:0] wd; logic [31:0] wdata; } wb_t;
  bus_t bus_q[$];
  wb_t  wb_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // Responder knobs: gnt after gnt_wait REQ cycles, rvalid rv_wait cycles after the one following gnt
  int          gnt_wait = 0;
  int          rv_wait  = 0;
  logic [31:0] rd_val   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus responder, drives just after each rising edge
  initial begin
    int   gcnt, rcnt;
    logic pend, gnt_we;
    gcnt = 0; rcnt = 0; pend = 1'b0; gnt_we = 1'b0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dbus_rvalid = 1'b0;
      if (dbus_gnt) begin
        dbus_gnt = 1'b0;
        if (!gnt_we) begin pend = 1'b1; rcnt = 0; end
      end
      if (pend) begin
        if (rcnt == rv_wait) begin
          dbus_rvalid = 1'b1; dbus_rdata = rd_val; pend = 1'b0;
        end else rcnt++;
      end
      if (dbus_req) begin
        if (gcnt == gnt_wait) begin dbus_gnt = 1'b1; gnt_we = dbus_we; gcnt = 0; end
        else gcnt++;
      end
    end
  end

  // Monitor: pops expectations on bus handshakes and write-back results
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dbus_req && dbus_gnt) begin
          if (bus_q.size() == 0) chk("bus_unexpected_req", dbus_addr, 32'hFFFF_FFFF);
          else begin
            bus_t e;
            e = bus_q.pop_front();
            chk("bus_addr", dbus_addr, e.addr);
            chk("bus_be", {28'b0, dbus_be}, {28'b0, e.be});
            chk("bus_we", {31'b0, dbus_we}, {31'b0, e.we});
            if (e.we) chk("bus_wdata", dbus_wdata, e.wdata);
          end
        end
        if (wb_wreg) begin
          if (wb_q.size() == 0) chk("wb_unexpected", wb_wdata, 32'hFFFF_FFFF);
          else begin
            wb_t w;
            w = wb_q.pop_front();
            chk("wb_wd", {27'b0, wb_wd}, {27'b0, w.wd});
            chk("wb_wdata", wb_wdata, w.wdata);
          end
        end
      end
    end
  end

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic re, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] sdata);
    in_wd = wd; in_wreg = wreg; in_wdata = wdata; in_mem_re = re; in_mem_we = we;
    in_memop = op; in_mem_addr = addr; in_mem_sdata = sdata;
  endtask

  task automatic nop();
    drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  // Present one instruction at a falling edge, hold it while stalled, and
  // check the number of cycles until upstream may advance.
  task automatic issue(input string nm, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic re, input logic we,
                       input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input int exp_cyc);
    int   cyc;
    logic s;
    drive(wd, wreg, wdata, re, we, op, addr, sdata);
    cyc = 0;
    do begin
      #1;
      s = stall_req;
      @(posedge clk); @(negedge clk);
      cyc++;
    end while (s && cyc < 50);
    chk({nm, "_cycles"}, cyc, exp_cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_req}, 32'h0);
    chk("rst_req", {31'b0, dbus_req}, 32'h0);
    chk("rst_wb_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("rst_wb_wd", {27'b0, wb_wd}, 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_dbus_addr", dbus_addr, 32'h0);
    chk("rst_dbus_be", {28'b0, dbus_be}, 32'h0);
`ifdef MISALIGN_EXC_EN
    chk("rst_exc", {31'b0, misalign_exc}, 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // ALU pass-through
    wb_q.push_back('{5'd5, 32'hDEAD_BEEF});
    issue("alu", 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1);

    // LB 0x102: byte 0x80 sign-extended; gnt after 2 waits, rvalid next cycle
    gnt_wait = 2; rv_wait = 0; rd_val = 32'h1280_FF34;
    bus_q.push_back('{32'h100, 4'b0100, 1'b0, 32'h0});
    wb_q.push_back('{5'd7, 32'hFFFF_FF80});
    issue("lb", 5'd7, 1'b1, 32'h0, 1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 5);

    // SH 0x206, gnt in the request cycle
    gnt_wait = 0;
    bus_q.push_back('{32'h204, 4'b1100, 1'b1, 32'hABCD_ABCD});
    issue("sh", 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b001, 32'h206, 32'h0000_ABCD, 2);

    // SB 0x303, re and we both set: store takes priority
    bus_q.push_back('{32'h300, 4'b1000, 1'b1, 32'h5555_5555});
    issue("sb_re_we", 5'd0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h303, 32'h1234_5655, 2);

    // SW with one gnt wait cycle
    gnt_wait = 1;
    bus_q.push_back('{32'h400, 4'b1111, 1'b1, 32'h1234_5678});
    issue("sw", 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'h400, 32'h1234_5678, 3);

    // LHU upper half, zero-extend
    gnt_wait = 0; rd_val = 32'h8001_1234;
    bus_q.push_back('{32'h000, 4'b1100, 1'b0, 32'h0});
    wb_q.push_back('{5'd10, 32'h0000_8001});
    issue("lhu", 5'd10, 1'b1, 32'h0, 1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 3);

    // LH lower half, sign-extend, rvalid delayed two cycles
    rv_wait = 2; rd_val = 32'h0000_8765;
    bus_q.push_back('{32'h000, 4'b0011, 1'b0, 32'h0});
    wb_q.push_back('{5'd11, 32'hFFFF_8765});
    issue("lh", 5'd11, 1'b1, 32'h0, 1'b1, 1'b0, 3'b001, 32'h000, 32'h0, 5);

    // LBU byte 1, zero-extend
    rv_wait = 0; rd_val = 32'h0000_9A00;
    bus_q.push_back('{32'h000, 4'b0010, 1'b0, 32'h0});
    wb_q.push_back('{5'd12, 32'h0000_009A});
    issue("lbu", 5'd12, 1'b1, 32'h0, 1'b1, 1'b0, 3'b100, 32'h001, 32'h0, 3);

    // LW then ALU op back to back
    rd_val = 32'hCAFE_F00D;
    bus_q.push_back('{32'h010, 4'b1111, 1'b0, 32'h0});
    wb_q.push_back('{5'd8, 32'hCAFE_F00D});
    wb_q.push_back('{5'd9, 32'h0000_0011});
    issue("lw", 5'd8, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h010, 32'h0, 3);
    chk("lw_wb_now", wb_wdata, 32'hCAFE_F00D);
    issue("alu_after_lw", 5'd9, 1'b1, 32'h11, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1);
    chk("alu_wb_next", wb_wdata, 32'h0000_0011);

    // Undefined memop 011 acts as a word load
    rd_val = 32'h0BAD_F00D;
    bus_q.push_back('{32'h020, 4'b1111, 1'b0, 32'h0});
    wb_q.push_back('{5'd13, 32'h0BAD_F00D});
    issue("lw_op3", 5'd13, 1'b1, 32'h0, 1'b1, 1'b0, 3'b011, 32'h020, 32'h0, 3);

`ifdef MISALIGN_EXC_EN
    // Misaligned LW: no bus, no stall, one-cycle exception pulse
    issue("lw_misal", 5'd4, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h1001, 32'h0, 1);
    nop();
    chk("misal_exc", {31'b0, misalign_exc}, 32'h1);
    chk("misal_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("misal_req", {31'b0, dbus_req}, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("misal_exc_drop", {31'b0, misalign_exc}, 32'h0);
`else
    // Misaligned LW without the exception: proceeds aligned
    rd_val = 32'h7777_1111;
    bus_q.push_back('{32'h1000, 4'b1111, 1'b0, 32'h0});
    wb_q.push_back('{5'd4, 32'h7777_1111});
    issue("lw_unaligned", 5'd4, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h1003, 32'h0, 3);
`endif

    // Reset while waiting for read data; the late rvalid must be ignored
    gnt_wait = 0; rv_wait = 4; rd_val = 32'h5A5A_5A5A;
    bus_q.push_back('{32'h600, 4'b1111, 1'b0, 32'h0});
    drive(5'd3, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("wait_stall", {31'b0, stall_req}, 32'h1);
    rst = 1'b1;
    nop();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    begin
      int t;
      t = 0;
      while (!dbus_rvalid && t < 10) begin @(posedge clk); @(negedge clk); t++; end
      chk("late_rvalid_seen", {31'b0, dbus_rvalid}, 32'h1);
    end
    chk("rst_rv_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("rst_rv_req", {31'b0, dbus_req}, 32'h0);
    chk("rst_rv_stall", {31'b0, stall_req}, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("rst_rv_wreg_after", {31'b0, wb_wreg}, 32'h0);

    // Normal operation resumes after reset
    rv_wait = 0; rd_val = 32'h1357_9BDF;
    bus_q.push_back('{32'h700, 4'b1111, 1'b0, 32'h0});
    wb_q.push_back('{5'd14, 32'h1357_9BDF});
    issue("lw_post_rst", 5'd14, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 3);
    nop();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 32'h0);
    chk("wb_q_empty", wb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
